// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Optional MADD/MSUB accumulate ops are enabled by defining MIPS_MULDIV_ACC_EN.
module mips_muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MIPS_MULDIV_ACC_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     raw_a;
    logic                 qneg, rneg, dz, is_div;
`ifdef MIPS_MULDIV_ACC_EN
    logic                 madd_r, msub_r;
`endif

    logic                 mul_op, div_op, signed_op, iter_op, accept;
    logic [WIDTH-1:0]     abs_a, abs_b;

    always_comb begin
        mul_op    = (op == OP_MULT) || (op == OP_MULTU);
        div_op    = (op == OP_DIV)  || (op == OP_DIVU);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
`ifdef MIPS_MULDIV_ACC_EN
        if (op == OP_MADD || op == OP_MSUB) begin
            mul_op    = 1'b1;
            signed_op = 1'b1;
        end
`endif
    end

    assign iter_op = mul_op || div_op;
    assign ready   = (state == IDLE);
    assign busy    = ~ready;
    assign accept  = start && ready && !flush;
    assign abs_a   = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b   = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // One iteration of each algorithm; acc holds {upper, lower} for multiply and {rem, quo} for divide.
    logic [WIDTH:0]       sum, shifted, diff;
    logic                 ge;
    logic [WIDTH-1:0]     rem_n;
    logic [2*WIDTH-1:0]   mul_step, div_step;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_step = {sum, acc[WIDTH-1:1]};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        ge       = ~diff[WIDTH];
        rem_n    = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_step = {rem_n, acc[WIDTH-2:0], ge};
    end

    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        prod = qneg ? -acc : acc;
        quo  = qneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && iter_op) state_n = CALC;
            CALC:    if (flush) state_n = IDLE;
                     else if (cnt == CNT_W'(WIDTH-1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            raw_a  <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            dz     <= 1'b0;
            is_div <= 1'b0;
`ifdef MIPS_MULDIV_ACC_EN
            madd_r <= 1'b0;
            msub_r <= 1'b0;
`endif
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            if (accept) begin
                if (iter_op) begin
                    cnt    <= '0;
                    qneg   <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    rneg   <= signed_op && src_a[WIDTH-1];
                    is_div <= div_op;
                    dz     <= div_op && (src_b == '0);
                    raw_a  <= src_a;
`ifdef MIPS_MULDIV_ACC_EN
                    madd_r <= (op == OP_MADD);
                    msub_r <= (op == OP_MSUB);
`endif
                    if (div_op) begin
                        acc  <= {{WIDTH{1'b0}}, abs_a};
                        opnd <= abs_b;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, abs_b};
                        opnd <= abs_a;
                    end
                end
                if (op == OP_MTHI) hi <= src_a;
                if (op == OP_MTLO) lo <= src_a;
            end
            if (state == CALC && !flush) begin
                cnt <= cnt + 1'b1;
                acc <= is_div ? div_step : mul_step;
            end
            if (state == FIX && !flush) begin
                done <= 1'b1;
                div0 <= is_div && dz;
                if (is_div) begin
                    // Divide-by-zero reports the raw dividend, bypassing sign correction.
                    if (dz) begin
                        hi <= raw_a;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                end else begin
`ifdef MIPS_MULDIV_ACC_EN
                    if (madd_r)      {hi, lo} <= {hi, lo} + prod;
                    else if (msub_r) {hi, lo} <= {hi, lo} - prod;
                    else             {hi, lo} <= prod;
`else
                    {hi, lo} <= prod;
`endif
                end
            end
        end
    end

endmodule
